// File: rtl/bike_light_ctrl.sv
// Rear-light control stage: button synchronizer and debouncer, 4-mode light FSM,
// and fast/slow blink generators paced by a shared timebase tick.
module bike_light_ctrl #(
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned FAST_HALF      = 125,
  parameter int unsigned SLOW_HALF      = 500,
  parameter int unsigned CNT_W          = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  input  logic       tick,
  output logic [1:0] state,
  output logic       fast_blink,
  output logic       slow_blink
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_ON     = 2'b01,
    ST_FLASH1 = 2'b10,
    ST_FLASH2 = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_HALF - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             btn_m;
  logic             btn_s;
  logic             db;
  logic             db_q;
  logic [CNT_W-1:0] db_cnt;
  logic             armed;
  logic [CNT_W-1:0] arm_cnt;
  logic             press;
  mode_e            mode_q;
  mode_e            mode_d;
  logic [CNT_W-1:0] fast_cnt;
  logic [CNT_W-1:0] slow_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= button;
      btn_s <= btn_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db     <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == db) begin
      db_cnt <= '0;
    end else if (tick) begin
      if (db_cnt == DB_LAST) begin
        db     <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_ONE;
      end
    end
  end

  // A button already held when reset releases must not count as a press:
  // presses are only armed once the input has been seen low for a full
  // debounce interval after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else if (!armed) begin
      if (btn_m || btn_s) begin
        arm_cnt <= '0;
      end else if (tick) begin
        if (arm_cnt == DB_LAST) begin
          armed   <= 1'b1;
          arm_cnt <= '0;
        end else begin
          arm_cnt <= arm_cnt + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q  <= 1'b0;
      press <= 1'b0;
    end else begin
      db_q  <= db;
      press <= db & ~db_q & armed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= ST_OFF;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (press) begin
      unique case (mode_q)
        ST_OFF:    mode_d = ST_ON;
        ST_ON:     mode_d = ST_FLASH1;
        ST_FLASH1: mode_d = ST_FLASH2;
        ST_FLASH2: mode_d = ST_OFF;
        default:   mode_d = ST_OFF;
      endcase
    end
  end

  // Generators key off the next mode so entry and exit land on the same edge
  // that updates the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fast_blink <= 1'b0;
      fast_cnt   <= '0;
    end else if (mode_d != ST_FLASH1) begin
      fast_blink <= 1'b0;
      fast_cnt   <= '0;
    end else if (mode_q != ST_FLASH1) begin
      fast_blink <= 1'b1;
      fast_cnt   <= '0;
    end else if (tick) begin
      if (fast_cnt == FAST_LAST) begin
        fast_blink <= ~fast_blink;
        fast_cnt   <= '0;
      end else begin
        fast_cnt <= fast_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_blink <= 1'b0;
      slow_cnt   <= '0;
    end else if (mode_d != ST_FLASH2) begin
      slow_blink <= 1'b0;
      slow_cnt   <= '0;
    end else if (mode_q != ST_FLASH2) begin
      slow_blink <= 1'b1;
      slow_cnt   <= '0;
    end else if (tick) begin
      if (slow_cnt == SLOW_LAST) begin
        slow_blink <= ~slow_blink;
        slow_cnt   <= '0;
      end else begin
        slow_cnt <= slow_cnt + CNT_ONE;
      end
    end
  end

  assign state = mode_q;

endmodule

// File: tb/tb_bike_light_ctrl.sv
// Directed bench for bike_light_ctrl: vector table for press/blink/bounce timing,
// hand sequences for half-rate tick and asynchronous reset mid-flash.
module tb_bike_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       button;
  logic       tick;
  logic [1:0] state;
  logic       fast_blink;
  logic       slow_blink;

  int unsigned total = 0;
  int unsigned bad   = 0;

  bike_light_ctrl #(
    .DEBOUNCE_TICKS(4),
    .FAST_HALF     (3),
    .SLOW_HALF     (6),
    .CNT_W         (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button    (button),
    .tick      (tick),
    .state     (state),
    .fast_blink(fast_blink),
    .slow_blink(slow_blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic       tk;
    int         n;
    logic [1:0] st;
    logic       f;
    logic       s;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic b, logic t, int n, logic [1:0] st, logic f, logic s);
    vec_t v;
    v.btn = b; v.tk = t; v.n = n; v.st = st; v.f = f; v.s = s;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [1:0] got, logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(logic b, logic t);
    button = b;
    tick   = t;
    @(posedge clk);
    #1;
  endtask

  task automatic press_from(logic [1:0] st_before, logic [1:0] st_after, string tag);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 1'b1);
      check({tag, ".state"}, state, (k < 7) ? st_before : st_after);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    button = 1'b0;
    tick   = 1'b1;

    // idle after reset
    add(0, 1, 20, 2'd0, 0, 0);
    // press 1: state 01 seven edges after the button edge, stable while held
    add(1, 1, 7, 2'd0, 0, 0);
    add(1, 1, 5, 2'd1, 0, 0);
    add(0, 1, 10, 2'd1, 0, 0);
    // press 2: FLASH1, fast half-period 3
    add(1, 1, 7, 2'd1, 0, 0);
    add(1, 1, 3, 2'd2, 1, 0);
    add(1, 1, 3, 2'd2, 0, 0);
    add(1, 1, 3, 2'd2, 1, 0);
    add(1, 1, 3, 2'd2, 0, 0);
    add(0, 1, 3, 2'd2, 1, 0);
    add(0, 1, 3, 2'd2, 0, 0);
    add(0, 1, 3, 2'd2, 1, 0);
    add(0, 1, 1, 2'd2, 0, 0);
    // press 3: fast keeps running until the exit edge, then slow starts high
    add(1, 1, 2, 2'd2, 0, 0);
    add(1, 1, 3, 2'd2, 1, 0);
    add(1, 1, 2, 2'd2, 0, 0);
    add(1, 1, 5, 2'd3, 0, 1);
    add(0, 1, 1, 2'd3, 0, 1);
    add(0, 1, 6, 2'd3, 0, 0);
    add(0, 1, 3, 2'd3, 0, 1);
    // press 4: wrap to OFF
    add(1, 1, 3, 2'd3, 0, 1);
    add(1, 1, 4, 2'd3, 0, 0);
    add(1, 1, 5, 2'd0, 0, 0);
    add(0, 1, 10, 2'd0, 0, 0);
    // bounce: 3 high / 2 low never reaches 4 ticks
    for (int r = 0; r < 5; r++) begin
      add(1, 1, 3, 2'd0, 0, 0);
      add(0, 1, 2, 2'd0, 0, 0);
    end
    add(0, 1, 10, 2'd0, 0, 0);
    // back to ON for the half-rate tick sequences
    add(1, 1, 7, 2'd0, 0, 0);
    add(1, 1, 5, 2'd1, 0, 0);
    add(0, 1, 10, 2'd1, 0, 0);

    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("reset.state", state, 2'd0);
      check("reset.fast", {1'b0, fast_blink}, 2'd0);
      check("reset.slow", {1'b0, slow_blink}, 2'd0);
    end
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        cyc(vecs[i].btn, vecs[i].tk);
        check($sformatf("v%0d.state", i), state, vecs[i].st);
        check($sformatf("v%0d.fast", i), {1'b0, fast_blink}, {1'b0, vecs[i].f});
        check($sformatf("v%0d.slow", i), {1'b0, slow_blink}, {1'b0, vecs[i].s});
      end
    end

    // FLASH1 with tick every 2nd cycle: half-period 6 cycles
    for (int r = 0; r <= 40; r++) begin
      cyc(r < 12, (r < 8) ? 1'b1 : 1'(r % 2));
      check("half_fast.state", state, (r < 7) ? 2'd1 : 2'd2);
      check("half_fast.fast", {1'b0, fast_blink},
            (r < 7) ? 2'd0 : {1'b0, 1'(((r - 7) / 6) % 2 == 0)});
      check("half_fast.slow", {1'b0, slow_blink}, 2'd0);
    end

    // FLASH2 with tick every 2nd cycle: half-period 12 cycles
    for (int r = 0; r <= 42; r++) begin
      cyc(r < 12, (r < 8) ? 1'b1 : 1'(r % 2));
      check("half_slow.state", state, (r < 7) ? 2'd2 : 2'd3);
      if (r >= 7) begin
        check("half_slow.fast", {1'b0, fast_blink}, 2'd0);
        check("half_slow.slow", {1'b0, slow_blink}, {1'b0, 1'(((r - 7) / 12) % 2 == 0)});
      end
    end

    // asynchronous reset mid-cycle while slow_blink is high, button held
    button = 1'b1;
    tick   = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst.state", state, 2'd0);
    check("async_rst.slow", {1'b0, slow_blink}, 2'd0);
    check("async_rst.fast", {1'b0, fast_blink}, 2'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1);
      check("in_rst.state", state, 2'd0);
      check("in_rst.slow", {1'b0, slow_blink}, 2'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc(1'b1, 1'b1);
      check("held_after_rst.state", state, 2'd0);
    end
    for (int k = 0; k < 15; k++) begin
      cyc(1'b0, 1'b1);
      check("release_after_rst.state", state, 2'd0);
    end
    press_from(2'd0, 2'd1, "press_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
